// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge PRG-ROM arbiter.
package cart_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DBG_WR      = 2'd1,
    DBG_RD_WAIT = 2'd2,
    DBG_RD_CAP  = 2'd3
  } arb_state_e;

  localparam logic PRG_NCE_IDLE  = 1'b1;
  localparam logic PRG_R_NW_IDLE = 1'b1;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cart_starve_timer.sv
// Counts cycles a debug request waits ungranted; raises a registered one-cycle stall at the limit.
// Latency: stall_o asserts the cycle after the count reaches STALL_THRESH; no backpressure.
module cart_starve_timer
  import cart_pkg::*;
#(
  parameter int STALL_THRESH = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pending_i,
  input  logic grant_i,
  output logic stall_o
);

  localparam int              CW     = clog2(STALL_THRESH + 1);
  localparam logic [CW-1:0]   THRESH = CW'(STALL_THRESH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (pending_i && (cnt_q != THRESH)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The stall cycle itself grants the debug request, so it can never repeat back to back.
    stall_d = pending_i && !grant_i && !stall_q && (cnt_q == THRESH);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/cart_prg_arbiter.sv
// Shares the cart PRG port between the CPU (priority) and the debug loader, with a starvation stall.
// Latency: debug write acks 1 cycle after grant, read 2 cycles; CPU is held via cpu_rdy_out.
module cart_prg_arbiter
  import cart_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 8,
  parameter int STALL_THRESH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  cpu_nce_in,
  input  logic [ADDR_WIDTH-1:0] cpu_a_in,
  input  logic                  cpu_r_nw_in,
  input  logic [DATA_WIDTH-1:0] cpu_d_in,
  output logic [DATA_WIDTH-1:0] cpu_d_out,
  output logic                  cpu_rdy_out,
  input  logic                  dbg_req_in,
  input  logic [ADDR_WIDTH-1:0] dbg_a_in,
  input  logic                  dbg_r_nw_in,
  input  logic [DATA_WIDTH-1:0] dbg_d_in,
  output logic [DATA_WIDTH-1:0] dbg_d_out,
  output logic                  dbg_ack_out,
  output logic                  prg_nce_out,
  output logic [ADDR_WIDTH-1:0] prg_a_out,
  output logic                  prg_r_nw_out,
  output logic [DATA_WIDTH-1:0] prg_d_out,
  input  logic [DATA_WIDTH-1:0] prg_d_in
);

  arb_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  cpu_rd_q, cpu_rd_d;
  logic [DATA_WIDTH-1:0] dbg_d_q, dbg_d_d;

  logic stall;
  logic cpu_rdy;
  logic cpu_gnt;
  logic dbg_pending;
  logic dbg_gnt;

  // RAM output in DBG_RD_WAIT belongs to the debug read, so the CPU is held off then.
  always_comb begin
    cpu_rdy     = !stall && (state_q != DBG_RD_WAIT);
    cpu_gnt     = !cpu_nce_in && cpu_rdy;
    dbg_pending = dbg_req_in && !busy_q;
    dbg_gnt     = dbg_pending && !cpu_gnt;
  end

  always_comb begin
    prg_nce_out  = PRG_NCE_IDLE;
    prg_a_out    = '0;
    prg_r_nw_out = PRG_R_NW_IDLE;
    prg_d_out    = '0;
    if (cpu_gnt) begin
      prg_nce_out  = 1'b0;
      prg_a_out    = cpu_a_in;
      prg_r_nw_out = cpu_r_nw_in;
      prg_d_out    = cpu_d_in;
    end else if (dbg_gnt) begin
      prg_nce_out  = 1'b0;
      prg_a_out    = dbg_a_in;
      prg_r_nw_out = dbg_r_nw_in;
      prg_d_out    = dbg_d_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    dbg_d_d     = dbg_d_q;
    dbg_ack_out = 1'b0;
    cpu_rd_d    = cpu_gnt && cpu_r_nw_in;
    case (state_q)
      IDLE: begin
        if (dbg_gnt) begin
          busy_d  = 1'b1;
          state_d = dbg_r_nw_in ? DBG_RD_WAIT : DBG_WR;
        end
      end
      DBG_WR: begin
        dbg_ack_out = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      DBG_RD_WAIT: begin
        dbg_d_d = prg_d_in;
        state_d = DBG_RD_CAP;
      end
      DBG_RD_CAP: begin
        dbg_ack_out = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cpu_rd_q <= 1'b0;
      dbg_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cpu_rd_q <= cpu_rd_d;
      dbg_d_q  <= dbg_d_d;
    end
  end

  cart_starve_timer #(
    .STALL_THRESH(STALL_THRESH)
  ) u_starve_timer (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .pending_i(dbg_pending),
    .grant_i  (dbg_gnt),
    .stall_o  (stall)
  );

  assign cpu_rdy_out = cpu_rdy;
  assign cpu_d_out   = cpu_rd_q ? prg_d_in : '0;
  assign dbg_d_out   = dbg_d_q;

endmodule

// File: tb/tb_cart_prg_arbiter.sv
// Bench for cart_prg_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_cart_prg_arbiter;

  localparam int AW     = 15;
  localparam int DW     = 8;
  localparam int THRESH = 8;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          cpu_nce_in;
  logic [AW-1:0] cpu_a_in;
  logic          cpu_r_nw_in;
  logic [DW-1:0] cpu_d_in;
  logic [DW-1:0] cpu_d_out;
  logic          cpu_rdy_out;
  logic          dbg_req_in;
  logic [AW-1:0] dbg_a_in;
  logic          dbg_r_nw_in;
  logic [DW-1:0] dbg_d_in;
  logic [DW-1:0] dbg_d_out;
  logic          dbg_ack_out;
  logic          prg_nce_out;
  logic [AW-1:0] prg_a_out;
  logic          prg_r_nw_out;
  logic [DW-1:0] prg_d_out;
  logic [DW-1:0] prg_rdata;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_in = ~clk_in;

  // Cart PRG RAM: one-cycle synchronous read, read-before-write.
  always @(posedge clk_in) begin
    if (!prg_nce_out) begin
      if (!prg_r_nw_out) ram[prg_a_out] <= prg_d_out;
      prg_rdata <= ram[prg_a_out];
    end
  end

  cart_prg_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STALL_THRESH(THRESH)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .cpu_nce_in  (cpu_nce_in),
    .cpu_a_in    (cpu_a_in),
    .cpu_r_nw_in (cpu_r_nw_in),
    .cpu_d_in    (cpu_d_in),
    .cpu_d_out   (cpu_d_out),
    .cpu_rdy_out (cpu_rdy_out),
    .dbg_req_in  (dbg_req_in),
    .dbg_a_in    (dbg_a_in),
    .dbg_r_nw_in (dbg_r_nw_in),
    .dbg_d_in    (dbg_d_in),
    .dbg_d_out   (dbg_d_out),
    .dbg_ack_out (dbg_ack_out),
    .prg_nce_out (prg_nce_out),
    .prg_a_out   (prg_a_out),
    .prg_r_nw_out(prg_r_nw_out),
    .prg_d_out   (prg_d_out),
    .prg_d_in    (prg_rdata)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu_idle();
    cpu_nce_in  = 1'b1;
    cpu_a_in    = '0;
    cpu_r_nw_in = 1'b1;
    cpu_d_in    = '0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    cpu_nce_in  = 1'b0;
    cpu_a_in    = a;
    cpu_r_nw_in = 1'b1;
    cpu_d_in    = '0;
  endtask

  task automatic dbg_idle();
    dbg_req_in  = 1'b0;
    dbg_a_in    = '0;
    dbg_r_nw_in = 1'b1;
    dbg_d_in    = '0;
  endtask

  task automatic dbg_drive(input logic [AW-1:0] a, input logic rnw, input logic [DW-1:0] d);
    dbg_req_in  = 1'b1;
    dbg_a_in    = a;
    dbg_r_nw_in = rnw;
    dbg_d_in    = d;
  endtask

  task automatic dbg_preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick();
    cpu_idle();
    dbg_drive(a, 1'b0, d);
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      if (dbg_ack_out === 1'b1) break;
    end
    ref_mem[a] = d;
    tick();
    dbg_idle();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    cpu_idle();
    dbg_idle();
    repeat (2) tick();
    settle();
    n_total++; if (prg_nce_out !== 1'b1) $display("FAIL rst_prg_nce got=%b exp=1", prg_nce_out); else n_pass++;
    n_total++; if (prg_r_nw_out !== 1'b1) $display("FAIL rst_prg_r_nw got=%b exp=1", prg_r_nw_out); else n_pass++;
    n_total++; if (prg_a_out !== 15'h0) $display("FAIL rst_prg_a got=%h exp=0", prg_a_out); else n_pass++;
    n_total++; if (prg_d_out !== 8'h00) $display("FAIL rst_prg_d got=%h exp=0", prg_d_out); else n_pass++;
    n_total++; if (cpu_rdy_out !== 1'b1) $display("FAIL rst_cpu_rdy got=%b exp=1", cpu_rdy_out); else n_pass++;
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL rst_dbg_ack got=%b exp=0", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'h00) $display("FAIL rst_dbg_d got=%h exp=0", dbg_d_out); else n_pass++;
    n_total++; if (cpu_d_out !== 8'h00) $display("FAIL rst_cpu_d got=%h exp=0", cpu_d_out); else n_pass++;
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      n_total++; if (prg_nce_out !== 1'b1) $display("FAIL idle_prg_nce cyc=%0d got=%b exp=1", i, prg_nce_out); else n_pass++;
      n_total++; if (cpu_rdy_out !== 1'b1) $display("FAIL idle_cpu_rdy cyc=%0d got=%b exp=1", i, cpu_rdy_out); else n_pass++;
      n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL idle_dbg_ack cyc=%0d got=%b exp=0", i, dbg_ack_out); else n_pass++;
    end
  endtask

  task automatic test_dbg_write_read();
    tick();
    dbg_drive(15'h4000, 1'b0, 8'hA5);
    settle();
    n_total++; if (prg_nce_out !== 1'b0) $display("FAIL wr_prg_nce got=%b exp=0", prg_nce_out); else n_pass++;
    n_total++; if (prg_r_nw_out !== 1'b0) $display("FAIL wr_prg_r_nw got=%b exp=0", prg_r_nw_out); else n_pass++;
    n_total++; if (prg_a_out !== 15'h4000) $display("FAIL wr_prg_a got=%h exp=4000", prg_a_out); else n_pass++;
    n_total++; if (prg_d_out !== 8'hA5) $display("FAIL wr_prg_d got=%h exp=a5", prg_d_out); else n_pass++;
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL wr_ack_early got=%b exp=0", dbg_ack_out); else n_pass++;
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b1) $display("FAIL wr_ack got=%b exp=1", dbg_ack_out); else n_pass++;
    n_total++; if (prg_nce_out !== 1'b1) $display("FAIL wr_ack_prg_nce got=%b exp=1", prg_nce_out); else n_pass++;
    ref_mem[15'h4000] = 8'hA5;
    tick();
    dbg_drive(15'h4000, 1'b1, 8'h00);
    settle();
    n_total++; if (prg_nce_out !== 1'b0) $display("FAIL rd_prg_nce got=%b exp=0", prg_nce_out); else n_pass++;
    n_total++; if (prg_r_nw_out !== 1'b1) $display("FAIL rd_prg_r_nw got=%b exp=1", prg_r_nw_out); else n_pass++;
    n_total++; if (prg_a_out !== 15'h4000) $display("FAIL rd_prg_a got=%h exp=4000", prg_a_out); else n_pass++;
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL rd_ack_early got=%b exp=0", dbg_ack_out); else n_pass++;
    n_total++; if (cpu_rdy_out !== 1'b0) $display("FAIL rd_wait_rdy got=%b exp=0", cpu_rdy_out); else n_pass++;
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b1) $display("FAIL rd_ack got=%b exp=1", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL rd_data got=%h exp=a5", dbg_d_out); else n_pass++;
    tick();
    dbg_idle();
    settle();
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL rd_ack_pulse got=%b exp=0", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL rd_data_hold got=%h exp=a5", dbg_d_out); else n_pass++;
  endtask

  task automatic test_priority();
    dbg_preload(15'h1234, 8'h3C);
    tick();
    cpu_read(15'h1234);
    dbg_drive(15'h4000, 1'b1, 8'h00);
    settle();
    n_total++; if (prg_a_out !== 15'h1234) $display("FAIL pri_cpu_a got=%h exp=1234", prg_a_out); else n_pass++;
    n_total++; if (prg_nce_out !== 1'b0) $display("FAIL pri_cpu_nce got=%b exp=0", prg_nce_out); else n_pass++;
    n_total++; if (cpu_rdy_out !== 1'b1) $display("FAIL pri_cpu_rdy got=%b exp=1", cpu_rdy_out); else n_pass++;
    tick();
    cpu_idle();
    settle();
    n_total++; if (prg_a_out !== 15'h4000) $display("FAIL pri_dbg_a got=%h exp=4000", prg_a_out); else n_pass++;
    n_total++; if (prg_nce_out !== 1'b0) $display("FAIL pri_dbg_nce got=%b exp=0", prg_nce_out); else n_pass++;
    n_total++; if (cpu_d_out !== 8'h3C) $display("FAIL pri_cpu_data got=%h exp=3c", cpu_d_out); else n_pass++;
    tick();
    settle();
    n_total++; if (cpu_rdy_out !== 1'b0) $display("FAIL pri_wait_rdy got=%b exp=0", cpu_rdy_out); else n_pass++;
    n_total++; if (cpu_d_out !== 8'h00) $display("FAIL pri_cpu_data_zero got=%h exp=0", cpu_d_out); else n_pass++;
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b1) $display("FAIL pri_ack got=%b exp=1", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL pri_dbg_data got=%h exp=a5", dbg_d_out); else n_pass++;
    tick();
    dbg_idle();
  endtask

  task automatic test_stall();
    bit prev_g;
    bit exp_rdy;
    dbg_preload(15'h0100, 8'h77);
    prev_g = 1'b0;
    for (int k = 0; k <= THRESH + 4; k++) begin
      tick();
      if (k == 0) begin
        cpu_read(15'h0100);
        dbg_drive(15'h4000, 1'b1, 8'h00);
      end
      if (k == THRESH + 4) dbg_idle();
      settle();
      exp_rdy = !((k == THRESH + 1) || (k == THRESH + 2));
      n_total++; if (cpu_rdy_out !== exp_rdy) $display("FAIL stall_rdy k=%0d got=%b exp=%b", k, cpu_rdy_out, exp_rdy); else n_pass++;
      n_total++; if (dbg_ack_out !== (k == THRESH + 3)) $display("FAIL stall_ack k=%0d got=%b exp=%b", k, dbg_ack_out, (k == THRESH + 3)); else n_pass++;
      n_total++; if (cpu_d_out !== (prev_g ? 8'h77 : 8'h00)) $display("FAIL stall_cpu_data k=%0d got=%h exp=%h", k, cpu_d_out, (prev_g ? 8'h77 : 8'h00)); else n_pass++;
      if (k == THRESH + 1) begin
        n_total++; if (prg_a_out !== 15'h4000) $display("FAIL stall_dbg_a got=%h exp=4000", prg_a_out); else n_pass++;
      end
      if (k == THRESH + 3) begin
        n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL stall_dbg_data got=%h exp=a5", dbg_d_out); else n_pass++;
      end
      prev_g = exp_rdy;
    end
    tick();
    cpu_idle();
  endtask

  task automatic test_rd_wait_cpu();
    dbg_preload(15'h7FFC, 8'hC3);
    tick();
    dbg_drive(15'h4000, 1'b1, 8'h00);
    settle();
    n_total++; if (prg_a_out !== 15'h4000) $display("FAIL rw_dbg_a got=%h exp=4000", prg_a_out); else n_pass++;
    tick();
    cpu_read(15'h7FFC);
    settle();
    n_total++; if (cpu_rdy_out !== 1'b0) $display("FAIL rw_cpu_held got=%b exp=0", cpu_rdy_out); else n_pass++;
    n_total++; if (prg_nce_out !== 1'b1) $display("FAIL rw_port_idle got=%b exp=1", prg_nce_out); else n_pass++;
    tick();
    settle();
    n_total++; if (cpu_rdy_out !== 1'b1) $display("FAIL rw_cpu_rdy got=%b exp=1", cpu_rdy_out); else n_pass++;
    n_total++; if (prg_a_out !== 15'h7FFC) $display("FAIL rw_cpu_a got=%h exp=7ffc", prg_a_out); else n_pass++;
    n_total++; if (dbg_ack_out !== 1'b1) $display("FAIL rw_ack got=%b exp=1", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL rw_dbg_data got=%h exp=a5", dbg_d_out); else n_pass++;
    tick();
    cpu_idle();
    dbg_idle();
    settle();
    n_total++; if (cpu_d_out !== 8'hC3) $display("FAIL rw_cpu_data got=%h exp=c3", cpu_d_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hA5) $display("FAIL rw_dbg_hold got=%h exp=a5", dbg_d_out); else n_pass++;
  endtask

  task automatic test_reset_midread();
    tick();
    dbg_drive(15'h7FFC, 1'b1, 8'h00);
    settle();
    n_total++; if (prg_nce_out !== 1'b0) $display("FAIL mr_grant got=%b exp=0", prg_nce_out); else n_pass++;
    tick();
    settle();
    n_total++; if (cpu_rdy_out !== 1'b0) $display("FAIL mr_wait_rdy got=%b exp=0", cpu_rdy_out); else n_pass++;
    #1;
    rst_n_in = 1'b0;
    dbg_idle();
    #1;
    n_total++; if (dbg_d_out !== 8'h00) $display("FAIL mr_dbg_d got=%h exp=0", dbg_d_out); else n_pass++;
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL mr_ack got=%b exp=0", dbg_ack_out); else n_pass++;
    n_total++; if (cpu_rdy_out !== 1'b1) $display("FAIL mr_rdy got=%b exp=1", cpu_rdy_out); else n_pass++;
    n_total++; if (prg_nce_out !== 1'b1) $display("FAIL mr_prg_nce got=%b exp=1", prg_nce_out); else n_pass++;
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL mr_ack_in_rst got=%b exp=0", dbg_ack_out); else n_pass++;
    tick();
    rst_n_in = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (dbg_ack_out !== 1'b0) $display("FAIL mr_no_ack cyc=%0d got=%b exp=0", i, dbg_ack_out); else n_pass++;
      n_total++; if (dbg_d_out !== 8'h00) $display("FAIL mr_dbg_d_post cyc=%0d got=%h exp=0", i, dbg_d_out); else n_pass++;
      tick();
      settle();
    end
    tick();
    dbg_drive(15'h7FFC, 1'b1, 8'h00);
    settle();
    n_total++; if (prg_a_out !== 15'h7FFC) $display("FAIL mr_new_a got=%h exp=7ffc", prg_a_out); else n_pass++;
    tick();
    settle();
    tick();
    settle();
    n_total++; if (dbg_ack_out !== 1'b1) $display("FAIL mr_new_ack got=%b exp=1", dbg_ack_out); else n_pass++;
    n_total++; if (dbg_d_out !== 8'hC3) $display("FAIL mr_new_data got=%h exp=c3", dbg_d_out); else n_pass++;
    tick();
    dbg_idle();
  endtask

  // Model: per pending request, grant at the first cycle the CPU is not selecting,
  // or unconditionally THRESH+1 cycles after the request; acks 1 (write) or 2 (read) cycles later.
  task automatic test_random();
    bit            d_act, c_held, prev_rd, exp_rdy, cgnt, dgnt, exp_ack;
    int            d_gap, d_req, d_gnt, d_ack, pct;
    logic [AW-1:0] d_a;
    logic          d_rnw;
    logic [DW-1:0] d_dat, d_exp, last_rd, prev_exp, exp_dbg_d, exp_cpu_d;
    tick();
    rst_n_in = 1'b0;
    cpu_idle();
    dbg_idle();
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 32; i++) dbg_preload(AW'(i), DW'($urandom));
    d_act = 1'b0; d_gap = 0; d_req = 0; d_gnt = -1; d_ack = -1;
    d_a = '0; d_rnw = 1'b1; d_dat = '0; d_exp = '0; last_rd = '0;
    c_held = 1'b0; prev_rd = 1'b0; prev_exp = '0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (!d_act) begin
        if (d_gap == 0) begin
          d_act = 1'b1;
          d_a   = AW'($urandom_range(0, 31));
          d_rnw = ($urandom_range(0, 1) == 1);
          d_dat = DW'($urandom);
          d_req = c;
          d_gnt = -1;
          d_ack = -1;
        end else begin
          d_gap--;
        end
      end
      if (d_act) dbg_drive(d_a, d_rnw, d_dat);
      else       dbg_idle();
      if (!c_held) begin
        pct = ((c / 200) % 2 == 1) ? 95 : 40;
        cpu_nce_in  = ($urandom_range(0, 99) >= pct);
        cpu_a_in    = AW'($urandom_range(0, 31));
        cpu_r_nw_in = ($urandom_range(0, 3) != 0);
        cpu_d_in    = DW'($urandom);
      end
      settle();
      exp_rdy = 1'b1;
      if (d_act && d_gnt < 0 && c == d_req + THRESH + 1) exp_rdy = 1'b0;
      if (d_act && d_gnt >= 0 && d_rnw && c == d_gnt + 1) exp_rdy = 1'b0;
      cgnt      = !cpu_nce_in && exp_rdy;
      dgnt      = d_act && (d_gnt < 0) && !cgnt;
      exp_ack   = d_act && (d_gnt >= 0) && (c == d_ack);
      exp_dbg_d = (exp_ack && d_rnw) ? d_exp : last_rd;
      exp_cpu_d = prev_rd ? prev_exp : '0;
      n_total++; if (cpu_rdy_out !== exp_rdy) $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, cpu_rdy_out, exp_rdy); else n_pass++;
      n_total++; if (prg_nce_out !== !(cgnt || dgnt)) $display("FAIL rnd_prg_nce c=%0d got=%b exp=%b", c, prg_nce_out, !(cgnt || dgnt)); else n_pass++;
      n_total++; if (dbg_ack_out !== exp_ack) $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, dbg_ack_out, exp_ack); else n_pass++;
      n_total++; if (dbg_d_out !== exp_dbg_d) $display("FAIL rnd_dbg_d c=%0d got=%h exp=%h", c, dbg_d_out, exp_dbg_d); else n_pass++;
      n_total++; if (cpu_d_out !== exp_cpu_d) $display("FAIL rnd_cpu_d c=%0d got=%h exp=%h", c, cpu_d_out, exp_cpu_d); else n_pass++;
      if (cgnt) begin
        n_total++; if (prg_a_out !== cpu_a_in || prg_r_nw_out !== cpu_r_nw_in) $display("FAIL rnd_cpu_port c=%0d got=%h/%b exp=%h/%b", c, prg_a_out, prg_r_nw_out, cpu_a_in, cpu_r_nw_in); else n_pass++;
      end
      if (dgnt) begin
        n_total++; if (prg_a_out !== d_a || prg_r_nw_out !== d_rnw) $display("FAIL rnd_dbg_port c=%0d got=%h/%b exp=%h/%b", c, prg_a_out, prg_r_nw_out, d_a, d_rnw); else n_pass++;
        if (!d_rnw) begin
          n_total++; if (prg_d_out !== d_dat) $display("FAIL rnd_dbg_wdata c=%0d got=%h exp=%h", c, prg_d_out, d_dat); else n_pass++;
        end
      end
      if (cgnt) begin
        prev_rd  = cpu_r_nw_in;
        prev_exp = ref_mem[cpu_a_in];
        if (!cpu_r_nw_in) ref_mem[cpu_a_in] = cpu_d_in;
      end else begin
        prev_rd = 1'b0;
      end
      c_held = !cpu_nce_in && !exp_rdy;
      if (dgnt) begin
        d_gnt = c;
        d_ack = c + (d_rnw ? 2 : 1);
        d_exp = ref_mem[d_a];
        if (!d_rnw) ref_mem[d_a] = d_dat;
      end
      if (exp_ack) begin
        if (d_rnw) last_rd = d_exp;
        d_act = 1'b0;
        d_gap = $urandom_range(0, 3);
      end
    end
    tick();
    cpu_idle();
    dbg_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0;
    cpu_idle();
    dbg_idle();
    test_reset();
    test_dbg_write_read();
    test_priority();
    test_stall();
    test_rd_wait_cpu();
    test_reset_midread();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cart_prg_arbiter.md
Name: cart_prg_arbiter

Overview:
Shares the cartridge PRG-ROM port between the CPU and the debug/host loader, which writes ROM images and reads them back. The CPU has priority. The loader gets idle cycles, and gets a forced slot (a one-cycle CPU stall) when it has waited too long. The block sits between the CPU/debug bus and the cart PRG interface, and handles the one-cycle synchronous read latency of the cart RAM.

Parameters:
ADDR_WIDTH, 15, PRG address width (matches cart prg_a).
DATA_WIDTH, 8, data width.
STALL_THRESH, 8, number of consecutive wait cycles of a pending debug request before the CPU is stalled; legal range 1..255.

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
cpu_nce_in  in  1  CPU cart-space select, active low
cpu_a_in  in  ADDR_WIDTH  CPU address
cpu_r_nw_in  in  1  CPU read(1)/write(0)
cpu_d_in  in  DATA_WIDTH  CPU write data
cpu_d_out  out  DATA_WIDTH  CPU read data
cpu_rdy_out  out  1  CPU ready; 0 = CPU must hold its access this cycle
dbg_req_in  in  1  debug access request
dbg_a_in  in  ADDR_WIDTH  debug address
dbg_r_nw_in  in  1  debug read(1)/write(0)
dbg_d_in  in  DATA_WIDTH  debug write data
dbg_d_out  out  DATA_WIDTH  debug read data, registered
dbg_ack_out  out  1  one-cycle completion pulse
prg_nce_out  out  1  to cart prg_nce_in
prg_a_out  out  ADDR_WIDTH  to cart prg_a_in
prg_r_nw_out  out  1  to cart prg_r_nw_in
prg_d_out  out  DATA_WIDTH  to cart prg_d_in
prg_d_in  in  DATA_WIDTH  from cart prg_d_out

Behaviour:
- Reset, asynchronous, rst_n_in=0:
  - cpu_rdy_out=1, dbg_ack_out=0, dbg_d_out=0, cpu_d_out=0.
  - wait counter=0, FSM=IDLE, busy=0.
  - Cart port is in its idle value.
  - Reset asserted mid-access aborts the access; no ack is issued afterwards.
- Cart idle value: prg_nce_out=1, prg_r_nw_out=1, prg_a_out=0, prg_d_out=0.
- Cart port values are chosen combinationally each cycle (the issue cycle N):
  - CPU grant: cpu_nce_in=0 and cpu_rdy_out=1. Cart port = CPU signals.
  - Else debug grant: a debug request is pending (dbg_req_in=1, busy=0). Cart port = dbg signals; set busy.
  - Else: idle value.
- CPU read data: in cycle N+1 after a CPU read grant, cpu_d_out=prg_d_in (combinational). Otherwise cpu_d_out=0.
- FSM states IDLE, DBG_WR, DBG_RD_WAIT, DBG_RD_CAP:
  - IDLE -> DBG_WR on a debug write grant. DBG_WR: dbg_ack_out=1 in N+1, clear busy, go to IDLE.
  - IDLE -> DBG_RD_WAIT on a debug read grant. DBG_RD_WAIT (N+1): capture prg_d_in into dbg_d_out at the end of the cycle, go to DBG_RD_CAP.
  - DBG_RD_CAP (N+2): dbg_ack_out=1, clear busy, go to IDLE.
  - Debug write latency = 1 cycle; debug read latency = 2 cycles.
  - dbg_d_out holds its value until the next debug read capture.
- Debug handshake:
  - dbg_req_in and its address/data/direction must stay stable until dbg_ack_out.
  - While busy, dbg_req_in is ignored.
  - dbg_req_in high in the ack cycle is not a new request. A new request is sampled from the cycle after ack.
- Starvation control:
  - The wait counter increments in each cycle where a debug request is pending but not granted (saturates at STALL_THRESH).
  - It clears on a debug grant.
  - When the counter equals STALL_THRESH, cpu_rdy_out (registered) goes to 0 for exactly the next cycle.
  - In that cycle the CPU is not granted even if cpu_nce_in=0, and the debug request is granted. cpu_rdy_out then returns to 1.
- Simultaneous events:
  - CPU and debug request in the same cycle with cpu_rdy_out=1: CPU wins, debug waits.
  - A CPU access in cycle N+1 may overlap a debug read in DBG_RD_WAIT. The cart RAM output in N+1 belongs to the debug read, so the CPU is not granted then: cpu_rdy_out is combinationally forced to 0 while in DBG_RD_WAIT.
- Address and data pass through without modification. No width conversion.

Decomposition:
- Package cart_pkg:
  - FSM state enum (IDLE, DBG_WR, DBG_RD_WAIT, DBG_RD_CAP).
  - Cart idle constants (nce=1, r_nw=1).
  - Counter width function clog2(STALL_THRESH+1).
- One sub-module: cart_starve_timer. Contains the wait counter and the registered stall pulse generator. Inputs pending/grant, output stall.

Test Plan:
- Reset release, no requests -> prg_nce_out=1, cpu_rdy_out=1, dbg_ack_out=0 indefinitely.
- Debug write a=0x4000, d=0xA5, CPU idle -> cart we cycle N with a=0x4000; dbg_ack_out pulse at N+1. Then debug read of 0x4000 -> dbg_d_out=0xA5 with ack at N+2.
- CPU and debug request in the same cycle -> CPU granted first. Debug granted the first cycle cpu_nce_in=1. Wait counter resets.
- CPU continuously selecting cart, debug read pending, STALL_THRESH=8 -> cpu_rdy_out=0 for exactly one cycle, 9 cycles after the request. Debug granted in that cycle. Then cpu_rdy_out=0 again for DBG_RD_WAIT. Ack follows.
- CPU read at 0x7FFC during DBG_RD_WAIT -> CPU held (cpu_rdy_out=0), read served next cycle. cpu_d_out shows correct data; dbg_d_out is not corrupted.
- rst_n_in pulsed low in DBG_RD_WAIT -> no ack, dbg_d_out=0, FSM=IDLE. New request after reset completes normally.
